// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: cascaded BCD up/down counter with load clamp, wrap pulse and optional compare (BCD_MATCH_EN)
module bcd_updown_counter #(
  parameter int DIGITS  = 4,
  parameter int MATCH_W = 4*DIGITS
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [MATCH_W-1:0] data_in_i,
  input  logic               counter_on_i,
  input  logic               counter_up_i,
`ifdef BCD_MATCH_EN
  input  logic [MATCH_W-1:0] match_value_i,
  output logic               match_o,
`endif
  output logic [MATCH_W-1:0] count_o,
  output logic               tc_o,
  output logic               load_err_o
);
  logic [MATCH_W-1:0] count_q, count_d, step_v, clamp_v;
  logic tc_q, tc_d, err_q, err_d, chain, bad;
  logic [3:0] dig, din;
  always_comb begin
    step_v = count_q;
    clamp_v = data_in_i;
    chain = 1'b1;
    bad = 1'b0;
    dig = 4'd0;
    din = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      din = data_in_i[4*i +: 4];
      step_v[4*i +: 4] = !chain ? dig : counter_up_i ? (dig == 4'd9 ? 4'd0 : dig + 4'd1)
                                                     : (dig == 4'd0 ? 4'd9 : dig - 4'd1);
      chain = chain & (counter_up_i ? dig == 4'd9 : dig == 4'd0);
      clamp_v[4*i +: 4] = din > 4'd9 ? 4'd9 : din;
      bad = bad | (din > 4'd9);
    end
    // chain survives the loop only when every digit sat at the wrap value
    count_d = load_i ? clamp_v : counter_on_i ? step_v : count_q;
    tc_d = !load_i & counter_on_i & chain;
    err_d = load_i & bad;
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
      tc_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q <= tc_d;
      err_q <= err_d;
    end
  end
`ifdef BCD_MATCH_EN
  logic match_q;
  always_ff @(posedge clock_i) begin
    if (reset_i) match_q <= 1'b0;
    else match_q <= count_q == match_value_i;
  end
  assign match_o = match_q;
`endif
  assign count_o = count_q;
  assign tc_o = tc_q;
  assign load_err_o = err_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: randomized and directed checks of a 2-digit counter against an integer model
module tb_bcd_updown_counter;
  logic clk = 1'b0;
  logic rst, ld, on, up, tc, err;
  logic [7:0] din, cnt, mv;
  logic match;
  int checks = 0, failures = 0;
  int m_cnt = 0;
  bit m_tc, m_err, m_match;

  bcd_updown_counter #(.DIGITS(2)) dut (
    .clock_i(clk), .reset_i(rst), .load_i(ld), .data_in_i(din),
    .counter_on_i(on), .counter_up_i(up),
`ifdef BCD_MATCH_EN
    .match_value_i(mv), .match_o(match),
`endif
    .count_o(cnt), .tc_o(tc), .load_err_o(err)
  );
`ifndef BCD_MATCH_EN
  assign match = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(bit r, bit l, logic [7:0] d, bit o, bit u);
    int hi, lo, old;
    rst = r; ld = l; din = d; on = o; up = u;
    old = m_cnt;
    if (r) begin
      m_cnt = 0; m_tc = 0; m_err = 0; m_match = 0;
    end else begin
      m_match = to_bcd(old) == mv;
      if (l) begin
        hi = int'(d[7:4]); lo = int'(d[3:0]);
        m_err = hi > 9 || lo > 9;
        m_cnt = (hi > 9 ? 9 : hi) * 10 + (lo > 9 ? 9 : lo);
        m_tc = 0;
      end else if (o) begin
        m_cnt = u ? (old + 1) % 100 : (old + 99) % 100;
        m_tc = u ? old == 99 : old == 0;
        m_err = 0;
      end else begin
        m_tc = 0; m_err = 0;
      end
    end
    @(posedge clk);
    #1;
    check("count", cnt, to_bcd(m_cnt));
    check("tc", tc, m_tc);
    check("load_err", err, m_err);
`ifdef BCD_MATCH_EN
    check("match", match, m_match);
`endif
  endtask

  initial begin
    mv = 8'h12;
    step(1, 0, 8'h00, 1, 1);
    check("reset_count", cnt, 8'h00);
    step(0, 1, 8'h98, 0, 1);
    step(0, 0, 8'h00, 1, 1);
    step(0, 0, 8'h00, 1, 1);
    check("wrap_up_tc", tc, 1'b1);
    step(0, 0, 8'h00, 0, 1);
    step(0, 1, 8'h10, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    check("borrow_09", cnt, 8'h09);
    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 1, 8'hA7, 0, 1);
    check("clamp_97", cnt, 8'h97);
    step(0, 1, 8'h35, 1, 1);
    step(0, 0, 8'h00, 0, 1);
    step(0, 1, 8'h45, 0, 1);
    step(0, 0, 8'h00, 1, 1);
    step(1, 1, 8'h77, 1, 1);
    step(0, 0, 8'h00, 1, 0);
    check("post_reset_down", cnt, 8'h99);
    step(0, 1, 8'h10, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 1);
    step(0, 1, 8'h99, 0, 1);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 1);
    step(0, 0, 8'h00, 1, 1);
    for (int i = 0; i < 500; i++) begin
      if (i % 50 == 0) mv = to_bcd($urandom_range(0, 99));
      step($urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0, 8'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 4, number of cascaded BCD digits (1..8).
REQ-002 Parameter MATCH_W, default 4*DIGITS, width of the match comparand (derived; SHALL NOT be overridden).
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load  input  1  parallel load strobe.
REQ-006 data_in  input  4*DIGITS  BCD load value; digit 0 is in bits [3:0].
REQ-007 counter_on  input  1  count enable.
REQ-008 counter_up  input  1  direction: 1 = up, 0 = down.
REQ-009 count  output  4*DIGITS  registered BCD count value.
REQ-010 TC  output  1  registered terminal-count (wrap) pulse.
REQ-011 load_err  output  1  registered pulse flagging an invalid load digit.
REQ-012 match_value  input  4*DIGITS  compare value (present only with BCD_MATCH_EN).
REQ-013 match  output  1  registered compare flag (present only with BCD_MATCH_EN).

Function
REQ-014 Update priority per edge SHALL be: reset > load > count > hold.
REQ-015 When load=1, count SHALL take data_in on that edge, regardless of counter_on; TC SHALL be 0 the following cycle.
REQ-016 Any data_in digit >9 on load SHALL be clamped to 9 in count, and load_err SHALL be 1 for exactly the following cycle; otherwise load_err SHALL be 0.
REQ-017 With load=0 and counter_on=0, count SHALL hold and TC SHALL be 0.
REQ-018 Up count: digit 0 SHALL increment every enabled edge; digit i>0 SHALL increment only when all lower digits equal 9; a digit at 9 that increments SHALL become 0.
REQ-019 Down count: digit 0 SHALL decrement every enabled edge; digit i>0 SHALL decrement only when all lower digits equal 0; a digit at 0 that decrements SHALL become 9.
REQ-020 Carry/borrow across all digits SHALL resolve within one clock (no ripple latency); count SHALL change exactly one edge after the enabled edge's sampled inputs.
REQ-021 TC SHALL be 1 for exactly one cycle after an enabled edge where count wrapped (all-9 to all-0 up, all-0 to all-9 down), and 0 otherwise; TC SHALL NOT be sticky.
REQ-022 A direction change SHALL take effect on the same edge it is sampled; no wrap SHALL occur unless the wrap condition of REQ-021 holds for the sampled direction.
REQ-023 Counting SHALL continue indefinitely through wraps; count SHALL never hold a non-BCD digit.

Reset
REQ-024 On reset=1 at a clock edge: count=0, TC=0, load_err=0, match=0, overriding load and counter_on.
REQ-025 Reset asserted mid-count SHALL discard any pending wrap; TC SHALL be 0 the following cycle.
REQ-026 After reset deassertion, the first enabled edge SHALL count from 0 (up: 0..01; down: all-9 with TC=1).

Configuration
REQ-027 Macro BCD_MATCH_EN: when defined, match_value and match SHALL exist; match SHALL be 1 in every cycle where the registered count equals match_value (registered one cycle after count updates), else 0; reset clears it.
REQ-028 When BCD_MATCH_EN is undefined, match_value and match SHALL be absent and no compare logic SHALL be synthesised; all other behaviour SHALL be identical.

Verification (DIGITS=2)
REQ-029 reset=1 one edge with counter_on=1 -> count=8'h00, TC=0, load_err=0.
REQ-030 load data_in=8'h98, then counter_on=1 up for 2 edges -> count 8'h99, then 8'h00 with TC=1 for one cycle only.
REQ-031 count=8'h10, down for 1 edge -> 8'h09, TC=0; from 8'h00 down 1 edge -> 8'h99, TC=1.
REQ-032 load data_in=8'hA7 -> count=8'h97, load_err=1 for one cycle; load with counter_on=1 -> load wins.
REQ-033 count=8'h45 up, reset=1 and load=1 same edge -> count=8'h00, TC=0.
REQ-034 With BCD_MATCH_EN, match_value=8'h12, count up from 8'h10 -> match=1 only for the cycle after count reaches 8'h12.
